miner_mem_responder: RTL and testbench
======================================

Name: miner_mem_responder

Overview:
- Memory-side responder for the parallel Bitcoin hash engine's memory master port (mem_addr / mem_we / mem_write_data / mem_read_data).
- Serves the 20-word block header to the miner from a host-loaded buffer.
- Captures the 8-word final hash written back for each nonce.
- When the miner signals done, scans all captured H0 words against a difficulty target and reports the best nonce to the host.

Parameters:
- NUM_NONCES, 16, number of nonce results written by the miner (power of 2, 2..64).
- MSG_BASE, 16'h0000, word address of header word 0 on the miner bus.
- OUT_BASE, 16'h0040, word address of nonce 0 / hash word 0 on the miner bus.

Ports:
- clk  input  1  single system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- hdr_wr_en  input  1  host write strobe into the header buffer.
- hdr_wr_idx  input  5  header word index 0..19; values 20..31 are ignored.
- hdr_wr_data  input  32  header word.
- target  input  32  difficulty threshold, sampled on the cycle miner_done is seen.
- scan_clear  input  1  host acknowledge; clears result_valid.
- mem_addr  input  16  miner word address.
- mem_we  input  1  miner write enable.
- mem_write_data  input  32  miner write data.
- mem_read_data  output  32  registered read data.
- miner_done  input  1  one-cycle done pulse from the miner.
- scan_busy  output  1  high while in SCAN.
- result_valid  output  1  scan result available.
- found  output  1  best_h0 < target (unsigned).
- best_nonce  output  $clog2(NUM_NONCES)  index of the minimum H0.
- best_h0  output  32  minimum H0 value.
- wr_count  output  8  saturating count of accepted hash writes.
- rd_oob  output  1  sticky: miner read outside the header window.
- wr_oob  output  1  sticky: miner write outside the hash window, or write during SCAN.

Behaviour:
- Reset: all outputs 0 and state IDLE. The header buffer (20x32) and hash buffer (8*NUM_NONCES x 32) are RAM and are not cleared.
- Read path: mem_read_data is registered.
  - An address sampled at edge t appears after edge t, i.e. one-cycle latency, independent of mem_we.
  - If MSG_BASE <= mem_addr < MSG_BASE+20, return header[mem_addr-MSG_BASE]. Otherwise return 0 and set rd_oob.
  - A host hdr_wr_en to the same index in the same cycle is read-before-write: the read returns the old word.
- Write path (state IDLE only): when mem_we=1 and OUT_BASE <= mem_addr < OUT_BASE+8*NUM_NONCES, store to hash[mem_addr-OUT_BASE] and increment wr_count (saturates at 255).
  - A write outside that window is dropped and sets wr_oob.
  - Hash word 0 of nonce n (H0) sits at offset 8n.
- Address arithmetic is 16-bit unsigned. Window upper bounds are computed 17-bit so they cannot wrap.
- FSM:
  - IDLE: bus active. On miner_done=1, latch target, clear result_valid and found, go to SCAN.
  - SCAN: one nonce per cycle, n = 0..NUM_NONCES-1.
    - Read H0 of nonce n; if strictly less than the running minimum (or n==0), update best_h0 and best_nonce.
    - Ties keep the lower index.
    - After n = NUM_NONCES-1, go to REPORT.
    - Miner writes in SCAN are dropped and set wr_oob. Reads are still served.
  - REPORT: one cycle. Set found = (best_h0 < latched target), set result_valid=1, go to IDLE.
- Latency: miner_done sampled at edge t gives scan_busy high for edges t+1..t+NUM_NONCES, and result_valid high after edge t+NUM_NONCES+1.
- result_valid, found, best_nonce and best_h0 hold until scan_clear=1 or the next miner_done. If both occur in the same cycle, miner_done wins and a new scan starts.
- miner_done during SCAN or REPORT is ignored.
- scan_clear also clears rd_oob, wr_oob and wr_count.
- Reset mid-SCAN returns to IDLE with all results cleared. The stored hash data is retained.

Test Plan:
1. Load header words 0..19 = 32'h1000_0000+i, then miner reads MSG_BASE+5 -> mem_read_data = 32'h1000_0005 one cycle later; read of 16'h0030 -> 0 and rd_oob=1.
2. Miner writes 128 words, H0 of nonce n = 32'hF000_0000-n*16'h100, then miner_done with target 32'hEFFF_FFFF -> scan_busy for 16 cycles; best_nonce=15, best_h0=32'hEFFF_F100, found=1, wr_count=128.
3. All H0 = 32'h8000_0000, target 32'h8000_0000 -> best_nonce=0 (tie keeps lowest), found=0 (strict less).
4. Miner write to OUT_BASE+128 and a write issued during SCAN -> both dropped, wr_oob=1, scan result unchanged.
5. Same-cycle hdr_wr_en idx 3 (new 32'hDEAD_BEEF) and miner read MSG_BASE+3 -> returns old word; the next read returns 32'hDEAD_BEEF.
6. Assert reset at SCAN cycle 7 -> state IDLE and all outputs 0; a following miner_done rescans the retained data and gives the same result as scenario 2.

Source files
------------

// File: rtl/miner_mem_responder.sv
// Memory-side responder for the hash miner: serves the block header,
// captures per-nonce hashes, and scans them for the best nonce.
// Ports: clk/reset; hdr_wr_* host header load; target/scan_clear host
// control; mem_* miner bus; miner_done scan trigger; scan_busy,
// result_valid, found, best_nonce, best_h0 results; wr_count, rd_oob,
// wr_oob bus status.
module miner_mem_responder #(
  parameter int          NUM_NONCES = 16,
  parameter logic [15:0] MSG_BASE   = 16'h0000,
  parameter logic [15:0] OUT_BASE   = 16'h0040
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          hdr_wr_en,
  input  logic [4:0]                    hdr_wr_idx,
  input  logic [31:0]                   hdr_wr_data,
  input  logic [31:0]                   target,
  input  logic                          scan_clear,
  input  logic [15:0]                   mem_addr,
  input  logic                          mem_we,
  input  logic [31:0]                   mem_write_data,
  output logic [31:0]                   mem_read_data,
  input  logic                          miner_done,
  output logic                          scan_busy,
  output logic                          result_valid,
  output logic                          found,
  output logic [$clog2(NUM_NONCES)-1:0] best_nonce,
  output logic [31:0]                   best_h0,
  output logic [7:0]                    wr_count,
  output logic                          rd_oob,
  output logic                          wr_oob
);

  localparam int NW = $clog2(NUM_NONCES);
  localparam int HW = NW + 3;
  localparam int HD = 8 * NUM_NONCES;

  // 17-bit window ends so a window near the top of the map cannot wrap
  localparam logic [16:0] MSG_END = {1'b0, MSG_BASE} + 17'd20;
  localparam logic [16:0] OUT_END = {1'b0, OUT_BASE} + 17'(HD);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_e;

  logic [31:0] hdr_q  [20];
  logic [31:0] hash_q [HD];

  state_e          state_q, state_d;
  logic [NW-1:0]   n_q, n_d;
  logic [31:0]     tgt_q, tgt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            valid_q, valid_d;
  logic            found_q, found_d;
  logic [NW-1:0]   bnonce_q, bnonce_d;
  logic [31:0]     bh0_q, bh0_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            rd_oob_q, rd_oob_d;
  logic            wr_oob_q, wr_oob_d;

  logic            rd_hit, wr_hit, hash_we;
  logic [4:0]      rd_idx;
  logic [HW-1:0]   wr_idx;
  logic [31:0]     h0;

  assign rd_hit = ({1'b0, mem_addr} >= {1'b0, MSG_BASE})
               && ({1'b0, mem_addr} <  MSG_END);
  assign wr_hit = ({1'b0, mem_addr} >= {1'b0, OUT_BASE})
               && ({1'b0, mem_addr} <  OUT_END);
  assign rd_idx = 5'(mem_addr - MSG_BASE);
  assign wr_idx = HW'(mem_addr - OUT_BASE);
  assign h0     = hash_q[{n_q, 3'b000}];

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    tgt_d    = tgt_q;
    valid_d  = valid_q;
    found_d  = found_q;
    bnonce_d = bnonce_q;
    bh0_d    = bh0_q;
    cnt_d    = cnt_q;
    rd_oob_d = rd_oob_q;
    wr_oob_d = wr_oob_q;
    hash_we  = 1'b0;

    rdata_d = rd_hit ? hdr_q[rd_idx] : 32'h0;

    if (scan_clear) begin
      rd_oob_d = 1'b0;
      wr_oob_d = 1'b0;
      cnt_d    = 8'h0;
    end

    // a cycle without a write is a read; flag it if off the header
    if (!mem_we && !rd_hit) rd_oob_d = 1'b1;

    if (mem_we) begin
      if (state_q == IDLE && wr_hit) begin
        hash_we = 1'b1;
        if (cnt_d != 8'hFF) cnt_d = cnt_d + 8'd1;
      end else begin
        wr_oob_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (miner_done) begin
          tgt_d   = target;
          valid_d = 1'b0;
          found_d = 1'b0;
          n_d     = '0;
          state_d = SCAN;
        end else if (scan_clear) begin
          valid_d  = 1'b0;
          found_d  = 1'b0;
          bnonce_d = '0;
          bh0_d    = 32'h0;
        end
      end
      SCAN: begin
        // strict less keeps the lower index on ties
        if (n_q == '0 || h0 < bh0_q) begin
          bh0_d    = h0;
          bnonce_d = n_q;
        end
        n_d = n_q + NW'(1);
        if (n_q == NW'(NUM_NONCES - 1)) state_d = REPORT;
      end
      REPORT: begin
        found_d = bh0_q < tgt_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      n_q      <= '0;
      tgt_q    <= 32'h0;
      rdata_q  <= 32'h0;
      valid_q  <= 1'b0;
      found_q  <= 1'b0;
      bnonce_q <= '0;
      bh0_q    <= 32'h0;
      cnt_q    <= 8'h0;
      rd_oob_q <= 1'b0;
      wr_oob_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      tgt_q    <= tgt_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      found_q  <= found_d;
      bnonce_q <= bnonce_d;
      bh0_q    <= bh0_d;
      cnt_q    <= cnt_d;
      rd_oob_q <= rd_oob_d;
      wr_oob_q <= wr_oob_d;
    end
  end

  // buffers are plain RAM: never reset, reads see the pre-write word
  always_ff @(posedge clk) begin
    if (hdr_wr_en && hdr_wr_idx < 5'd20) hdr_q[hdr_wr_idx] <= hdr_wr_data;
    if (hash_we) hash_q[wr_idx] <= mem_write_data;
  end

  assign mem_read_data = rdata_q;
  assign scan_busy     = (state_q == SCAN);
  assign result_valid  = valid_q;
  assign found         = found_q;
  assign best_nonce    = bnonce_q;
  assign best_h0       = bh0_q;
  assign wr_count      = cnt_q;
  assign rd_oob        = rd_oob_q;
  assign wr_oob        = wr_oob_q;

endmodule

// File: tb/tb_miner_mem_responder.sv
// Directed bench for miner_mem_responder with a read-data scoreboard
// and a reference result model for each scan.
module tb_miner_mem_responder;

  localparam int          N   = 16;
  localparam logic [15:0] MB  = 16'h0000;
  localparam logic [15:0] OB  = 16'h0040;

  typedef struct packed {
    logic [31:0] nonce;
    logic [31:0] h0;
    logic [31:0] fnd;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        hdr_wr_en;
  logic [4:0]  hdr_wr_idx;
  logic [31:0] hdr_wr_data;
  logic [31:0] target;
  logic        scan_clear;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        miner_done;
  logic        scan_busy;
  logic        result_valid;
  logic        found;
  logic [3:0]  best_nonce;
  logic [31:0] best_h0;
  logic [7:0]  wr_count;
  logic        rd_oob;
  logic        wr_oob;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] hdr_m  [20];
  logic [31:0] hash_m [8*N];
  logic [31:0] rd_q   [$];
  res_t        res_q  [$];

  miner_mem_responder #(
    .NUM_NONCES(N), .MSG_BASE(MB), .OUT_BASE(OB)
  ) dut (
    .clk(clk), .reset(reset),
    .hdr_wr_en(hdr_wr_en), .hdr_wr_idx(hdr_wr_idx),
    .hdr_wr_data(hdr_wr_data), .target(target),
    .scan_clear(scan_clear), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .miner_done(miner_done),
    .scan_busy(scan_busy), .result_valid(result_valid),
    .found(found), .best_nonce(best_nonce), .best_h0(best_h0),
    .wr_count(wr_count), .rd_oob(rd_oob), .wr_oob(wr_oob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobes_low();
    hdr_wr_en  = 1'b0;
    mem_we     = 1'b0;
    miner_done = 1'b0;
    scan_clear = 1'b0;
    mem_addr   = MB;
  endtask

  task automatic hdr_wr(input int i, input logic [31:0] d);
    @(negedge clk);
    hdr_wr_en = 1'b1; hdr_wr_idx = 5'(i); hdr_wr_data = d;
    @(posedge clk); #1;
    strobes_low();
    if (i < 20) hdr_m[i] = d;
  endtask

  task automatic rd(input string tag, input logic [15:0] a);
    logic [31:0] e;
    if (a >= MB && a < MB + 16'd20) rd_q.push_back(hdr_m[a - MB]);
    else rd_q.push_back(32'h0);
    @(negedge clk);
    mem_addr = a; mem_we = 1'b0;
    @(posedge clk); #1;
    strobes_low();
    if (rd_q.size() == 0) chk("rd_q_empty", 32'd1, 32'd0);
    else begin
      e = rd_q.pop_front();
      chk(tag, mem_read_data, e);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_addr = a; mem_we = 1'b1; mem_write_data = d;
    @(posedge clk); #1;
    strobes_low();
    if (a >= OB && a < OB + 16'(8*N)) hash_m[a - OB] = d;
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    scan_clear = 1'b1;
    @(posedge clk); #1;
    strobes_low();
  endtask

  function automatic res_t model(input logic [31:0] tgt);
    res_t r;
    r.nonce = 0;
    r.h0    = hash_m[0];
    for (int n = 1; n < N; n++)
      if (hash_m[8*n] < r.h0) begin
        r.h0    = hash_m[8*n];
        r.nonce = n;
      end
    r.fnd = {31'h0, r.h0 < tgt};
    return r;
  endfunction

  // inject: mid-scan write to nonce 0 H0, a stray done, and a new target
  task automatic scan_run(input string tag, input logic [31:0] tgt,
                          input bit inject);
    int   cnt;
    res_t e;
    res_q.push_back(model(tgt));
    @(negedge clk);
    miner_done = 1'b1; target = tgt;
    @(posedge clk); #1;
    strobes_low();
    cnt = 0;
    while (scan_busy && cnt < 100) begin
      cnt++;
      if (inject && cnt == 4) begin
        @(negedge clk);
        mem_addr = OB; mem_we = 1'b1; mem_write_data = 32'h0;
        miner_done = 1'b1; target = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        strobes_low();
      end else begin
        @(posedge clk); #1;
      end
    end
    chk({tag, "_busy_len"}, 32'(cnt), 32'(N));
    chk({tag, "_report_valid"}, 32'(result_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(result_valid), 32'd1);
    if (res_q.size() == 0) chk("res_q_empty", 32'd1, 32'd0);
    else begin
      e = res_q.pop_front();
      chk({tag, "_nonce"}, 32'(best_nonce), e.nonce);
      chk({tag, "_h0"}, best_h0, e.h0);
      chk({tag, "_found"}, 32'(found), e.fnd);
    end
  endtask

  initial begin
    reset = 1'b1;
    hdr_wr_idx = 5'd0; hdr_wr_data = 32'h0;
    target = 32'h0; mem_write_data = 32'h0;
    strobes_low();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(scan_busy), 32'd0);
    chk("rst_rdata", mem_read_data, 32'd0);
    chk("rst_cnt", 32'(wr_count), 32'd0);
    chk("rst_nonce", 32'(best_nonce), 32'd0);
    chk("rst_h0", best_h0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // header load and reads
    for (int i = 0; i < 20; i++) hdr_wr(i, 32'h1000_0000 + i);
    rd("rd_w5", MB + 16'd5);
    chk("rd_oob_clean", 32'(rd_oob), 32'd0);
    rd("rd_w19", MB + 16'd19);
    rd("rd_w20_oob", MB + 16'd20);
    rd("rd_0x30", 16'h0030);
    chk("rd_oob_set", 32'(rd_oob), 32'd1);
    clear_pulse();
    chk("clr_rd_oob", 32'(rd_oob), 32'd0);

    // descending H0 -> last nonce is best
    for (int n = 0; n < N; n++)
      for (int w = 0; w < 8; w++)
        wr(OB + 16'(8*n + w),
           (w == 0) ? 32'hF000_0000 - 32'(n) * 32'h100 : $urandom);
    chk("wr_cnt_128", 32'(wr_count), 32'd128);
    chk("wr_oob_clean", 32'(wr_oob), 32'd0);
    scan_run("s2", 32'hEFFF_FFFF, 1'b0);
    chk("s2_h0_abs", best_h0, 32'hEFFF_F100);

    // write just past the window, result must hold
    wr(OB + 16'(8*N), 32'h1234_5678);
    chk("oob_wr_flag", 32'(wr_oob), 32'd1);
    chk("oob_wr_cnt", 32'(wr_count), 32'd128);
    chk("oob_hold_valid", 32'(result_valid), 32'd1);
    chk("oob_hold_nonce", 32'(best_nonce), 32'd15);

    // reset at scan cycle 7, then rescan the retained hashes
    @(negedge clk);
    miner_done = 1'b1; target = 32'hEFFF_FFFF;
    @(posedge clk); #1;
    strobes_low();
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy", 32'(scan_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_busy", 32'(scan_busy), 32'd0);
    chk("mr_valid", 32'(result_valid), 32'd0);
    chk("mr_found", 32'(found), 32'd0);
    chk("mr_h0", best_h0, 32'd0);
    chk("mr_cnt", 32'(wr_count), 32'd0);
    chk("mr_wr_oob", 32'(wr_oob), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    scan_run("s6", 32'hEFFF_FFFF, 1'b0);

    // read-before-write on the header
    hdr_m[3] = 32'h1000_0003;
    rd_q.push_back(hdr_m[3]);
    @(negedge clk);
    hdr_wr_en = 1'b1; hdr_wr_idx = 5'd3; hdr_wr_data = 32'hDEAD_BEEF;
    mem_addr = MB + 16'd3;
    @(posedge clk); #1;
    strobes_low();
    hdr_m[3] = 32'hDEAD_BEEF;
    if (rd_q.size() == 0) chk("rd_q_empty", 32'd1, 32'd0);
    else chk("rbw_old", mem_read_data, rd_q.pop_front());
    rd("rbw_new", MB + 16'd3);

    // host acknowledge
    clear_pulse();
    chk("clr_valid", 32'(result_valid), 32'd0);
    chk("clr_found", 32'(found), 32'd0);
    chk("clr_cnt", 32'(wr_count), 32'd0);

    // equal H0s: lowest index wins, equality is not found
    for (int n = 0; n < N; n++) wr(OB + 16'(8*n), 32'h8000_0000);
    chk("s3_cnt", 32'(wr_count), 32'd16);
    scan_run("s3", 32'h8000_0000, 1'b1);
    chk("s3_wr_oob", 32'(wr_oob), 32'd1);
    chk("s3_cnt_after", 32'(wr_count), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
